// File: rtl/accum_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : accum_pkg
//  Description : Shared constants, FSM state encoding and overflow helper for
//                the accum_ctrl predictor-sum sequencer.
//  Revision    : 1.0  initial release
// ============================================================================
package accum_pkg;

   // Word width of products, W and S.
   localparam int unsigned c_word_w   = 16;
   // Number of partial products fed per transaction (wb1..wb6, wa1, wa2).
   localparam int unsigned c_term_cnt = 8;
   // Width of the feed counter.
   localparam int unsigned c_cnt_w    = $clog2(c_term_cnt);
   // Feed index during which S holds the six-term (sez) partial sum.
   localparam logic [c_cnt_w-1:0] c_sez_idx   = c_cnt_w'(6);
   // Last feed index before draining.
   localparam logic [c_cnt_w-1:0] c_last_term = c_cnt_w'(c_term_cnt - 1);

   // Sequencer states, explicit 3-bit encoding.
   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_CLR   = 3'd1,
      ST_GAP   = 3'd2,
      ST_FEED  = 3'd3,
      ST_DRAIN = 3'd4,
      ST_DONE  = 3'd5
   } state_t;

   // Two's-complement add overflow: same-sign operands, result of other sign.
   function automatic logic add_ovf(input logic [c_word_w-1:0] a,
                                    input logic [c_word_w-1:0] b,
                                    input logic [c_word_w-1:0] sum);
      return (a[c_word_w-1] == b[c_word_w-1]) && (sum[c_word_w-1] != a[c_word_w-1]);
   endfunction

endpackage
`default_nettype wire

// File: rtl/accum_ctrl_fsm.sv
`default_nettype none
// ============================================================================
//  Module      : accum_ctrl_fsm
//  Description : State register and feed counter for accum_ctrl. Exposes both
//                current and next state/count so the top level can register
//                its outputs aligned with the state they belong to.
//  Revision    : 1.0  initial release
// ============================================================================
module accum_ctrl_fsm
   import accum_pkg::*;
(
   input  logic               clk,
   input  logic               reset,
   input  logic               i_start,
   output state_t             o_state,
   output state_t             o_state_nxt,
   output logic [c_cnt_w-1:0] o_cnt,
   output logic [c_cnt_w-1:0] o_cnt_nxt,
   output logic               o_accept
);

   state_t               r_state;
   state_t               w_state_nxt;
   logic [c_cnt_w-1:0]   r_cnt;
   logic [c_cnt_w-1:0]   w_cnt_nxt;
   logic                 w_accept;

   // State and feed counter registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= ST_IDLE;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   // Next-state logic; counter is zero outside FEED and advances once per FEED cycle.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = '0;
      w_accept    = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (i_start) begin
               w_state_nxt = ST_CLR;
               w_accept    = 1'b1;
            end
         end
         ST_CLR:   w_state_nxt = ST_GAP;
         ST_GAP:   w_state_nxt = ST_FEED;
         ST_FEED: begin
            if (r_cnt == c_last_term) begin
               w_state_nxt = ST_DRAIN;
            end else begin
               w_cnt_nxt = r_cnt + c_cnt_w'(1);
            end
         end
         ST_DRAIN: w_state_nxt = ST_DONE;
         ST_DONE:  w_state_nxt = ST_IDLE;
         default:  w_state_nxt = ST_IDLE;
      endcase
   end

   assign o_state     = r_state;
   assign o_state_nxt = w_state_nxt;
   assign o_cnt       = r_cnt;
   assign o_cnt_nxt   = w_cnt_nxt;
   assign o_accept    = w_accept;

endmodule
`default_nettype wire

// File: rtl/accum_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : accum_ctrl
//  Description : Sequences eight signed partial products into an external
//                ACCUM register (clear, gap, 8 feeds, drain, done) and
//                captures the six-term (sez) and eight-term (se) sums.
//                Optional feature macro: ACCUM_CTRL_OVF_EN enables a shadow
//                sum with a sticky signed-overflow flag; otherwise ovf = 0.
//  Revision    : 1.0  initial release
// ============================================================================
module accum_ctrl
   import accum_pkg::*;
(
   input  logic                clk,
   input  logic                reset,
   input  logic                scan_in0,
   input  logic                scan_in1,
   input  logic                scan_in2,
   input  logic                scan_in3,
   input  logic                scan_in4,
   input  logic                scan_enable,
   input  logic                test_mode,
   output logic                scan_out0,
   output logic                scan_out1,
   output logic                scan_out2,
   output logic                scan_out3,
   output logic                scan_out4,
   input  logic                start,
   input  logic [c_word_w-1:0] wb1,
   input  logic [c_word_w-1:0] wb2,
   input  logic [c_word_w-1:0] wb3,
   input  logic [c_word_w-1:0] wb4,
   input  logic [c_word_w-1:0] wb5,
   input  logic [c_word_w-1:0] wb6,
   input  logic [c_word_w-1:0] wa1,
   input  logic [c_word_w-1:0] wa2,
   input  logic [c_word_w-1:0] S,
   output logic                clear,
   output logic [c_word_w-1:0] W,
   output logic                busy,
   output logic                done,
   output logic [c_word_w-2:0] sez,
   output logic [c_word_w-2:0] se,
   output logic                ovf
);

   state_t               w_state;
   state_t               w_state_nxt;
   logic [c_cnt_w-1:0]   w_cnt;
   logic [c_cnt_w-1:0]   w_cnt_nxt;
   logic                 w_accept;

   logic [c_word_w-1:0]  r_prod [c_term_cnt];
   logic [c_word_w-1:0]  w_w_nxt;
   logic [c_word_w-1:0]  r_w;
   logic                 r_clear;
   logic                 r_busy;
   logic                 r_done;
   logic [c_word_w-2:0]  r_sez;
   logic [c_word_w-2:0]  r_se;
   logic                 w_unused_s0;

   accum_ctrl_fsm u_fsm (
      .clk         (clk),
      .reset       (reset),
      .i_start     (start),
      .o_state     (w_state),
      .o_state_nxt (w_state_nxt),
      .o_cnt       (w_cnt),
      .o_cnt_nxt   (w_cnt_nxt),
      .o_accept    (w_accept)
   );

   // Products are captured once on the accepting edge; inputs may change afterwards.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_prod <= '{default: '0};
      end else if (w_accept) begin
         r_prod <= '{wb1, wb2, wb3, wb4, wb5, wb6, wa1, wa2};
      end
   end

   // Addend for the coming cycle: the indexed product in FEED, zero elsewhere.
   always_comb begin
      w_w_nxt = '0;
      if (w_state_nxt == ST_FEED) begin
         w_w_nxt = r_prod[w_cnt_nxt];
      end
   end

   // Outputs are registered from the next state so they line up with the state itself.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_clear <= 1'b0;
         r_w     <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_clear <= (w_state_nxt == ST_CLR);
         r_w     <= w_w_nxt;
         r_busy  <= (w_state_nxt != ST_IDLE);
         r_done  <= (w_state_nxt == ST_DONE);
      end
   end

   // Capture S/2 after six terms (sez) and after all eight (se); hold otherwise.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_sez <= '0;
         r_se  <= '0;
      end else begin
         if ((w_state == ST_FEED) && (w_cnt == c_sez_idx)) begin
            r_sez <= S[c_word_w-1:1];
         end
         if (w_state == ST_DRAIN) begin
            r_se <= S[c_word_w-1:1];
         end
      end
   end

`ifdef ACCUM_CTRL_OVF_EN
   logic [c_word_w-1:0] r_shadow;
   logic [c_word_w-1:0] w_shadow_sum;
   logic                r_ovf;

   assign w_shadow_sum = r_shadow + r_w;

   // Shadow of the ACCUM sum; ovf is sticky until reset or the next accepted start.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_shadow <= '0;
         r_ovf    <= 1'b0;
      end else begin
         if (w_state == ST_CLR) begin
            r_shadow <= '0;
         end else if (w_state == ST_FEED) begin
            r_shadow <= w_shadow_sum;
         end
         if (w_accept) begin
            r_ovf <= 1'b0;
         end else if ((w_state == ST_FEED) && add_ovf(r_shadow, r_w, w_shadow_sum)) begin
            r_ovf <= 1'b1;
         end
      end
   end

   assign ovf = r_ovf;
`else
   assign ovf = 1'b0;
`endif

   assign clear = r_clear;
   assign W     = r_w;
   assign busy  = r_busy;
   assign done  = r_done;
   assign sez   = r_sez;
   assign se    = r_se;

   // S[0] is dropped by the halving capture.
   assign w_unused_s0 = S[0];

   // Scan chains are stitched at scan insertion; gated pass-through until then.
   assign scan_out0 = test_mode & scan_enable & scan_in0;
   assign scan_out1 = test_mode & scan_enable & scan_in1;
   assign scan_out2 = test_mode & scan_enable & scan_in2;
   assign scan_out3 = test_mode & scan_enable & scan_in3;
   assign scan_out4 = test_mode & scan_enable & scan_in4;

endmodule
`default_nettype wire

// File: tb/tb_accum_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_accum_ctrl
//  Description : Self-checking bench for accum_ctrl driving a behavioural
//                ACCUM register. Honours ACCUM_CTRL_OVF_EN for ovf expectations.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_accum_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [15:0] drv_p [8];
   logic [15:0] S;
   logic        clear, busy, done, ovf;
   logic [15:0] W;
   logic [14:0] sez, se;
   logic        so0, so1, so2, so3, so4;

   // Transaction expectations
   logic [15:0] cur_p [8];
   logic [14:0] exp_sez, exp_se;
   logic [15:0] exp_total;
   bit          ovf_after [8];

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   accum_ctrl dut (
      .clk(clk), .reset(reset),
      .scan_in0(1'b0), .scan_in1(1'b0), .scan_in2(1'b0), .scan_in3(1'b0), .scan_in4(1'b0),
      .scan_enable(1'b0), .test_mode(1'b0),
      .scan_out0(so0), .scan_out1(so1), .scan_out2(so2), .scan_out3(so3), .scan_out4(so4),
      .start(start),
      .wb1(drv_p[0]), .wb2(drv_p[1]), .wb3(drv_p[2]), .wb4(drv_p[3]),
      .wb5(drv_p[4]), .wb6(drv_p[5]), .wa1(drv_p[6]), .wa2(drv_p[7]),
      .S(S), .clear(clear), .W(W), .busy(busy), .done(done),
      .sez(sez), .se(se), .ovf(ovf)
   );

   // Behavioural ACCUM: clear to zero, otherwise accumulate W.
   always @(posedge clk or negedge reset) begin
      if (!reset)     S <= '0;
      else if (clear) S <= '0;
      else            S <= S + W;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks = n_checks + 1;
      assert (obs === exp) n_pass = n_pass + 1;
      else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference: running 16-bit wrapped sum; overflow when the true sum leaves 16-bit range.
   task automatic predict();
      int          run;
      int          t;
      bit          any;
      logic [15:0] w16;
      run = 0;
      any = 0;
      for (int j = 0; j < 8; j++) begin
         t = run + int'($signed(cur_p[j]));
         if (t > 32767 || t < -32768) any = 1;
         w16 = 16'(t);
         run = int'($signed(w16));
         ovf_after[j] = any;
         if (j == 5) exp_sez = w16[15:1];
         if (j == 7) begin
            exp_se    = w16[15:1];
            exp_total = w16;
         end
      end
`ifndef ACCUM_CTRL_OVF_EN
      for (int j = 0; j < 8; j++) ovf_after[j] = 0;
`endif
   endtask

   task automatic load(input logic [15:0] p0, input logic [15:0] p1, input logic [15:0] p2,
                       input logic [15:0] p3, input logic [15:0] p4, input logic [15:0] p5,
                       input logic [15:0] p6, input logic [15:0] p7);
      cur_p = '{p0, p1, p2, p3, p4, p5, p6, p7};
      drv_p = cur_p;
      predict();
   endtask

   function automatic logic [15:0] rnd_word();
      logic [15:0] v;
      case ($urandom_range(0, 5))
         0:       v = 16'h7FFF;
         1:       v = 16'h8000;
         2:       v = 16'hFFFF;
         default: v = 16'($urandom);
      endcase
      return v;
   endfunction

   task automatic load_random();
      load(rnd_word(), rnd_word(), rnd_word(), rnd_word(),
           rnd_word(), rnd_word(), rnd_word(), rnd_word());
   endtask

   // Timeline of one transaction, entered in its first cycle (CLR is cycle 1):
   // cycles 3..10 feed the products, done is high in cycle 12.
   task automatic txn_body(input bit hold);
      logic [15:0] ew;
      int          idx;
      for (int j = 0; j < 8; j++) drv_p[j] = 16'($urandom);
      for (int k = 1; k <= 12; k++) begin
         ew  = (k >= 3 && k <= 10) ? cur_p[k-3] : 16'h0000;
         idx = (k - 4 > 7) ? 7 : k - 4;
         chk("clear", clear, (k == 1));
         chk("W", W, ew);
         chk("busy", busy, 1);
         chk("done", done, (k == 12));
         chk("ovf", ovf, (k >= 4) ? ovf_after[idx] : 0);
         if (k == 11) chk("S_total", S, exp_total);
         if (k == 12) begin
            chk("sez", sez, exp_sez);
            chk("se", se, exp_se);
         end
         start = hold ? 1'b1 : 1'($urandom_range(0, 1));
         tick();
      end
      start = hold;
      chk("idle_busy", busy, 0);
      chk("idle_done", done, 0);
      chk("hold_sez", sez, exp_sez);
      chk("hold_se", se, exp_se);
   endtask

   task automatic run_txn();
      start = 1'b1;
      tick();
      start = 1'b0;
      txn_body(0);
   endtask

   initial begin
      reset = 1'b0;
      start = 1'b0;
      for (int j = 0; j < 8; j++) drv_p[j] = '0;
      repeat (3) tick();

      // Reset state
      chk("rst_clear", clear, 0);
      chk("rst_W", W, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_sez", sez, 0);
      chk("rst_se", se, 0);
      chk("rst_ovf", ovf, 0);

      // Start already high at release: accepted on the first edge after release
      load(16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7, 16'd8);
      start = 1'b1;
      reset = 1'b1;
      tick();
      start = 1'b0;
      txn_body(0);
      chk("dir_sez_1to8", sez, 15'h000A);
      chk("dir_se_1to8", se, 15'h0012);

      // All ones
      load(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF);
      run_txn();
      chk("dir_sez_ffff", sez, 15'h7FFD);
      chk("dir_se_ffff", se, 15'h7FFC);
      chk("dir_ovf_ffff", ovf, 0);

      // Overflow on the second feed
      load(16'h7000, 16'h7000, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0);
      run_txn();
      chk("dir_se_7000", se, 15'h7000);
`ifdef ACCUM_CTRL_OVF_EN
      chk("dir_ovf_7000", ovf, 1);
`else
      chk("dir_ovf_7000", ovf, 0);
`endif

      // All zeros
      load(16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0);
      run_txn();
      chk("dir_sez_zero", sez, 15'h0);
      chk("dir_se_zero", se, 15'h0);

      // Start held high: back-to-back transactions 13 cycles apart
      start = 1'b1;
      for (int n = 0; n < 3; n++) begin
         load_random();
         tick();
         txn_body(1);
      end
      start = 1'b0;
      tick();

      // Reset during FEED with counter 3: abandon, no done afterwards
      load_random();
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (5) tick();
      chk("mid_W_cnt3", W, cur_p[3]);
      #2 reset = 1'b0;
      #1;
      chk("mid_clear", clear, 0);
      chk("mid_W", W, 0);
      chk("mid_busy", busy, 0);
      chk("mid_done", done, 0);
      chk("mid_sez", sez, 0);
      chk("mid_se", se, 0);
      chk("mid_ovf", ovf, 0);
      tick();
      reset = 1'b1;
      for (int c = 0; c < 14; c++) begin
         chk("post_rst_done", done, 0);
         chk("post_rst_busy", busy, 0);
         tick();
      end

      // Randomized transactions
      for (int n = 0; n < 15; n++) begin
         load_random();
         run_txn();
         repeat ($urandom_range(0, 2)) tick();
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/accum_ctrl.md
ACCUM_CTRL -- requirements
Module: accum_ctrl

Interface
REQ-001 SHALL have port: clk  input  1  single system clock, all state on rising edge.
REQ-002 SHALL have port: reset  input  1  asynchronous, active-low reset.
REQ-003 SHALL have ports: scan_in0..scan_in4  input  1 each  scan chain inputs.
REQ-004 SHALL have ports: scan_enable, test_mode  input  1 each  scan control.
REQ-005 SHALL have ports: scan_out0..scan_out4  output  1 each  scan chain outputs.
REQ-006 SHALL have port: start  input  1  request a predictor sum; sampled only in IDLE.
REQ-007 SHALL have ports: wb1..wb6, wa1, wa2  input  16 each  signed partial products, captured on accepted start.
REQ-008 SHALL have port: S  input  16  accumulator register value returned by ACCUM.
REQ-009 SHALL have port: clear  output  1  registered clear strobe to ACCUM.
REQ-010 SHALL have port: W  output  16  registered addend to ACCUM.
REQ-011 SHALL have port: busy  output  1  high in every state except IDLE.
REQ-012 SHALL have port: done  output  1  one-cycle pulse; sez/se are valid from this cycle.
REQ-013 SHALL have ports: sez  output  15  S[15:1] after six WB terms; se  output  15  S[15:1] after all eight terms.
REQ-014 SHALL have port: ovf  output  1  sticky signed-overflow flag (see Configuration).

Function
REQ-015 SHALL implement FSM IDLE -> CLR -> GAP -> FEED -> DRAIN -> DONE -> IDLE.
REQ-016 Transition: IDLE to CLR on start=1 at a rising edge, latching all eight products in that same edge.
REQ-017 Transition: CLR (clear=1, W=0) lasts 1 cycle; GAP (clear=0, W=0) lasts 1 cycle.
REQ-018 Transition: FEED lasts 8 cycles; 3-bit counter 0..7 drives W = wb1, wb2, wb3, wb4, wb5, wb6, wa1, wa2 in order.
REQ-019 SHALL capture sez <= S[15:1] at the end of the FEED cycle with counter=6, when S holds wb1+...+wb6.
REQ-020 DRAIN (W=0) lasts 1 cycle; SHALL capture se <= S[15:1] at the end of DRAIN.
REQ-021 DONE lasts 1 cycle with done=1; busy drops on return to IDLE.
REQ-022 done SHALL rise exactly 12 cycles after the accepting edge.
REQ-023 start asserted while busy=1 SHALL be ignored, including in the DONE cycle; no queueing.
REQ-024 sez/se SHALL hold their last values until overwritten by the next transaction.
REQ-025 Arithmetic is 16-bit two's complement, wrap-around; the block never modifies W values.

Reset
REQ-026 reset=0 SHALL asynchronously force IDLE, counter=0, clear=0, W=0, busy=0, done=0, sez=0, se=0, ovf=0.
REQ-027 reset asserted mid-transaction SHALL abandon the transaction; no done pulse follows release.
REQ-028 First start accepted on the first rising edge after reset release.

Configuration
REQ-029 Macro ACCUM_CTRL_OVF_EN defined: block SHALL keep a 16-bit shadow sum, cleared in CLR and added with W in FEED.
REQ-030 With the macro, ovf SHALL set when a shadow add overflows (same-sign operands, result of opposite sign), and clear only on reset or an accepted start.
REQ-031 Macro undefined: no shadow sum is present and ovf is tied to 0.

Structure
REQ-032 Shared package accum_pkg SHALL hold the FSM state enum, the term count constant (8), the SEZ capture index (6), and the word width constant (16).
REQ-033 SHALL use one sub-module, accum_ctrl_fsm (state register and counter); product latching and the W mux stay in the top level.

Verification
REQ-034 Products wb1..wb6=1..6, wa1=7, wa2=8 driven into an ACCUM instance -> S sequence matches, sez=0x000A (S=21), se=0x0012 (S=36), done at cycle 12.
REQ-035 All products 0xFFFF -> sez=0x7FFD, se=0x7FFC, ovf=0.
REQ-036 start held high continuously -> transactions accepted every 13 cycles; start in a busy or DONE cycle is ignored.
REQ-037 reset pulsed low during FEED counter=3 -> all outputs 0 immediately, no done pulse; next start completes normally.
REQ-038 With ACCUM_CTRL_OVF_EN defined: wb1=wb2=0x7000, others 0 -> ovf=1 after FEED cycle 1, se=0x7000; without the macro, ovf=0.
REQ-039 Products all 0 -> clear high exactly one cycle, sez=se=0.
